// File: rtl/sar_adc_ctrl_if.sv
// rtl/sar_adc_ctrl_if.sv - conversion request/result and analog SAR core signals
// The master drives start and the comparator level; the controller is the slave.
interface sar_adc_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             cmp_in;
   logic             sample_en;
   logic [WIDTH-1:0] dac_code;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             valid;

   modport master (
      output start,
      output cmp_in,
      input  sample_en,
      input  dac_code,
      input  busy,
      input  done,
      input  result,
      input  valid
   );

   modport slave (
      input  start,
      input  cmp_in,
      output sample_en,
      output dac_code,
      output busy,
      output done,
      output result,
      output valid
   );
endinterface

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC conversion controller
// Tracks the input for SAMPLE_CYCLES, then resolves one bit per SETTLE_CYCLES, MSB first.
module sar_adc_ctrl #(
   parameter int WIDTH         = 8,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   sar_adc_ctrl_if.slave bus
);
   localparam int IW  = $clog2(WIDTH);
   localparam int SMW = $clog2(SAMPLE_CYCLES) + 1;
   localparam int STW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [IW-1:0]  IDX_TOP     = IW'(WIDTH - 1);
   localparam logic [SMW-1:0] SAMPLE_LAST = SMW'(SAMPLE_CYCLES - 1);
   localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      CONVERT
   } state_e;

   state_e           state_q, state_d;
   logic [SMW-1:0]   samp_cnt_q, samp_cnt_d;
   logic [STW-1:0]   settle_cnt_q, settle_cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             sample_en_q, sample_en_d;
   logic [WIDTH-1:0] dac_code_q, dac_code_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] acc_kept;

   assign bit_mask = WIDTH'(1) << idx_q;

   always_comb begin
      state_d      = state_q;
      samp_cnt_d   = samp_cnt_q;
      settle_cnt_d = settle_cnt_q;
      idx_d        = idx_q;
      acc_d        = acc_q;
      sample_en_d  = sample_en_q;
      dac_code_d   = dac_code_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      result_d     = result_q;
      valid_d      = valid_q;
      // The trial code already carries bit i set, so keeping the bit means adopting it.
      acc_kept     = bus.cmp_in ? dac_code_q : acc_q;

      case (state_q)
         IDLE: begin
            sample_en_d = 1'b0;
            dac_code_d  = '0;
            busy_d      = 1'b0;
            if (bus.start) begin
               state_d      = SAMPLE;
               busy_d       = 1'b1;
               sample_en_d  = 1'b1;
               acc_d        = '0;
               idx_d        = IDX_TOP;
               samp_cnt_d   = '0;
               settle_cnt_d = '0;
            end
         end
         SAMPLE: begin
            if (samp_cnt_q == SAMPLE_LAST) begin
               state_d      = CONVERT;
               sample_en_d  = 1'b0;
               dac_code_d   = acc_q | bit_mask;
               settle_cnt_d = '0;
            end else begin
               samp_cnt_d = samp_cnt_q + 1'b1;
            end
         end
         CONVERT: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               acc_d        = acc_kept;
               settle_cnt_d = '0;
               if (idx_q == '0) begin
                  state_d    = IDLE;
                  result_d   = acc_kept;
                  done_d     = 1'b1;
                  valid_d    = 1'b1;
                  busy_d     = 1'b0;
                  dac_code_d = '0;
               end else begin
                  idx_d      = idx_q - 1'b1;
                  dac_code_d = acc_kept | (bit_mask >> 1);
               end
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         samp_cnt_q   <= '0;
         settle_cnt_q <= '0;
         idx_q        <= '0;
         acc_q        <= '0;
         sample_en_q  <= 1'b0;
         dac_code_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         samp_cnt_q   <= samp_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         sample_en_q  <= sample_en_d;
         dac_code_q   <= dac_code_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         result_q     <= result_d;
         valid_q      <= valid_d;
      end
   end

   assign bus.sample_en = sample_en_q;
   assign bus.dac_code  = dac_code_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.valid     = valid_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - scoreboard bench for sar_adc_ctrl at default and minimal parameters
module tb_sar_adc_ctrl;
   localparam int LAT8 = 4 + 8 * 2;
   localparam int LAT4 = 1 + 4 * 1;

   typedef struct {
      logic [15:0] res;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;
   logic [7:0] vin8;
   logic [3:0] vin4;
   exp_t q8[$];
   exp_t q4[$];
   logic [7:0] trials [8];
   logic [7:0] dac_log [20];
   logic       se_log [20];

   sar_adc_ctrl_if #(.WIDTH(8)) bus8 ();
   sar_adc_ctrl_if #(.WIDTH(4)) bus4 ();

   sar_adc_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   sar_adc_ctrl #(.WIDTH(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   // Ideal comparator standing in for the analog core.
   assign bus8.cmp_in = (vin8 >= bus8.dac_code);
   assign bus4.cmp_in = (vin4 >= bus4.dac_code);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push8(input logic [15:0] res, input int c);
      exp_t e;
      e.res = res;
      e.cyc = c;
      q8.push_back(e);
   endtask

   task automatic push4(input logic [15:0] res, input int c);
      exp_t e;
      e.res = res;
      e.cyc = c;
      q4.push_back(e);
   endtask

   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst === 1'b0 && bus8.done === 1'b1) begin
         if (q8.size() == 0) begin
            check("unexpected_done8", 32'd1, 32'd0);
         end else begin
            e = q8.pop_front();
            check("result8", 32'(bus8.result), 32'(e.res));
            check("done_cycle8", cyc, e.cyc);
            check("valid8", 32'(bus8.valid), 32'd1);
         end
      end
   end

   always @(negedge clk) begin : mon4
      exp_t e;
      if (rst === 1'b0 && bus4.done === 1'b1) begin
         if (q4.size() == 0) begin
            check("unexpected_done4", 32'd1, 32'd0);
         end else begin
            e = q4.pop_front();
            check("result4", 32'(bus4.result), 32'(e.res));
            check("done_cycle4", cyc, e.cyc);
            check("valid4", 32'(bus4.valid), 32'd1);
         end
      end
   end

   task automatic check_zero8(input string tag);
      check({tag, "_sample_en"}, 32'(bus8.sample_en), 32'd0);
      check({tag, "_dac_code"}, 32'(bus8.dac_code), 32'd0);
      check({tag, "_busy"}, 32'(bus8.busy), 32'd0);
      check({tag, "_done"}, 32'(bus8.done), 32'd0);
      check({tag, "_result"}, 32'(bus8.result), 32'd0);
      check({tag, "_valid"}, 32'(bus8.valid), 32'd0);
   endtask

   // Caller is at a negedge; returns at the negedge where busy has dropped (the done cycle).
   task automatic run8(input logic [7:0] v, input logic [7:0] exp, input int ign_a, input int ign_b);
      int n;
      vin8 = v;
      bus8.start = 1'b1;
      push8(16'(exp), cyc + 1 + LAT8);
      @(negedge clk);
      bus8.start = 1'b0;
      check("busy_after_start8", 32'(bus8.busy), 32'd1);
      n = 0;
      while (bus8.busy === 1'b1 && n < 100) begin
         n++;
         bus8.start = (n == ign_a || n == ign_b);
         @(negedge clk);
      end
      bus8.start = 1'b0;
      check("busy_cycles8", n, LAT8);
   endtask

   task automatic run4(input logic [3:0] v, input logic [3:0] exp);
      int n;
      vin4 = v;
      bus4.start = 1'b1;
      push4(16'(exp), cyc + 1 + LAT4);
      @(negedge clk);
      bus4.start = 1'b0;
      n = 0;
      while (bus4.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles4", n, LAT4);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      rst = 1'b1;
      vin8 = 8'h00;
      vin4 = 4'h0;
      bus8.start = 1'b0;
      bus4.start = 1'b0;

      repeat (3) @(negedge clk);
      check_zero8("reset");
      check("reset_busy4", 32'(bus4.busy), 32'd0);
      check("reset_result4", 32'(bus4.result), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero8("idle_reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(bus8.busy), 32'd0);
         check("idle_done", 32'(bus8.done), 32'd0);
      end

      // Nominal conversion with per-cycle trace of sample_en and trial codes.
      vin8 = 8'hA5;
      bus8.start = 1'b1;
      push8(16'hA5, cyc + 1 + LAT8);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         bus8.start = 1'b0;
         dac_log[k] = bus8.dac_code;
         se_log[k]  = bus8.sample_en;
      end
      for (int k = 0; k < 20; k++) begin
         check($sformatf("sample_en_c%0d", k + 1), 32'(se_log[k]), (k < 4) ? 32'd1 : 32'd0);
         check($sformatf("trial_c%0d", k + 1), 32'(dac_log[k]), (k < 4) ? 32'd0 : 32'(trials[(k - 4) / 2]));
      end
      @(negedge clk);
      @(negedge clk);
      check("idle_after_nominal", 32'(bus8.busy), 32'd0);

      // Extremes, the second one started in the done cycle of the first.
      run8(8'h00, 8'h00, -1, -1);
      run8(8'hFF, 8'hFF, -1, -1);
      run8(8'h5A, 8'h5A, 4, 14);
      repeat (3) @(negedge clk);

      // Held start: three conversions spaced 21 cycles apart.
      vin8 = 8'h3C;
      bus8.start = 1'b1;
      for (int i = 0; i < 3; i++) push8(16'h3C, cyc + 1 + LAT8 + i * (LAT8 + 1));
      begin
         int seen;
         int n;
         seen = 0;
         n = 0;
         while (seen < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus8.done === 1'b1) seen++;
         end
         bus8.start = 1'b0;
         check("held_start_dones", seen, 32'd3);
      end
      repeat (3) @(negedge clk);

      // Reset in the middle of a conversion following a completed 0xA5.
      run8(8'hA5, 8'hA5, -1, -1);
      @(negedge clk);
      vin8 = 8'h77;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_reset_busy", 32'(bus8.busy), 32'd1);
      #2 rst = 1'b1;
      #1 check_zero8("midconv_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("post_reset_valid", 32'(bus8.valid), 32'd0);
      check("post_reset_busy", 32'(bus8.busy), 32'd0);

      // Minimal-parameter instance.
      run4(4'h9, 4'h9);
      run4(4'hF, 4'hF);
      run4(4'h0, 4'h0);
      repeat (3) @(negedge clk);

      check("queue8_empty", q8.size(), 32'd0);
      check("queue4_empty", q4.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Successive-approximation controller for the on-die analog front end. Reads the analog comparator through the digital input path and drives the track/hold switch and capacitive-DAC trial code back into the analog macro. Returns a WIDTH-bit conversion result to the digital side. Sits between the top-level tile pins (start/result) and the analog SAR core (sample_en, dac_code, cmp_in).

Parameters:
WIDTH, 8, result/DAC resolution in bits; legal range 2..16.
SAMPLE_CYCLES, 4, clock cycles sample_en is held high; must be >= 1.
SETTLE_CYCLES, 2, clock cycles each trial code is held before cmp_in is sampled; must be >= 1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a conversion; sampled on the rising edge.
cmp_in  input  1  comparator output: 1 = Vin >= Vdac(dac_code), 0 = Vin < Vdac. Treated as stable when sampled.
sample_en  output  1  track/hold switch: 1 = tracking input.
dac_code  output  WIDTH  trial code driven to the DAC.
busy  output  1  conversion in progress.
done  output  1  one-cycle pulse when result updates.
result  output  WIDTH  last completed conversion; held until the next done.
valid  output  1  result holds at least one completed conversion since reset.

Behaviour:
- Reset (async assert, any state): state=IDLE; sample_en=0, dac_code=0, busy=0, done=0, result=0, valid=0; all counters and the accumulator are 0. Reset mid-conversion aborts it with no done pulse. The first start is accepted on the first rising edge after rst deasserts.
- All outputs are registered. No combinational path from start or cmp_in to any output.
- States: IDLE, SAMPLE, CONVERT.
- IDLE: sample_en=0, dac_code=0, busy=0. If start=1 at edge E0: go to SAMPLE, busy=1, sample_en=1, clear accumulator, set bit index i=WIDTH-1.
- SAMPLE: sample_en stays high for exactly SAMPLE_CYCLES cycles (edges E0..E(S)). At E(S): sample_en=0, dac_code = accumulator OR (1<<i), go to CONVERT.
- CONVERT: each trial code is held for SETTLE_CYCLES cycles. cmp_in is sampled at the edge ending the last settle cycle.
  - cmp_in=1: keep bit i. cmp_in=0: clear bit i.
  - If i>0: decrement i and drive the next trial code (decided bits OR (1<<i-1)) on that same edge.
  - If i=0: result = final accumulator, done=1 for one cycle, valid=1, busy=0, dac_code=0, go to IDLE.
- Latency: done is high in the cycle after edge E(SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES). With default parameters that is E20. busy is high for exactly 20 cycles.
- start while busy=1 is ignored (not queued).
- start=1 in the cycle where done=1: the FSM is already in IDLE, so the request is accepted. Back-to-back conversions therefore have no dead cycle.
- start held high continuously gives repeated conversions, each SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES + 1 cycles apart (edge to edge).
- result and valid change only at done or at reset. result is stable while the next conversion runs.
- Boundaries:
  - cmp_in always 1 gives result = all-ones.
  - cmp_in always 0 gives result = 0.
  - No wrap-around: the bit index stops at 0.
  - The settle counter width is clog2(SETTLE_CYCLES)+1.
- Trial code is monotone within a conversion: only bit i and lower bits change per step.

Test Plan:
- Reset values: assert rst mid-idle -> all outputs 0. Release rst, hold start=0 for 50 cycles -> busy=0, done never pulses.
- Nominal (defaults), model cmp_in = (Vin >= dac_code) with Vin=0xA5, pulse start:
  - trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held 2 cycles;
  - sample_en high cycles 1-4;
  - done at cycle 21 (one cycle after E20), result=0xA5, valid=1.
- Extremes: Vin=0x00 -> result 0x00 with every trial rejected. Vin=0xFF -> result 0xFF. Each takes exactly 20 busy cycles.
- Start handling:
  - pulse start again at cycles 5 and 15 of a conversion -> ignored, only one done;
  - start=1 coincident with done -> the next conversion begins with no idle gap;
  - start held high with Vin 0x3C -> done every 21 cycles, result 0x3C each time.
- Reset mid-conversion: assert rst at cycle 10 after a prior result 0xA5 -> busy, sample_en, dac_code, result and valid go to 0 immediately (asynchronous), and no done pulse occurs.
- Parameter sweep WIDTH=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=1, Vin=0x9 -> done one cycle after E5, result=0x9.
